// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t    : FSM state encoding (IDLE / RUN / DONE)
//   cnt_width  : bit-counter width for a given operand width
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter only has to reach width-1, so clog2(width) bits suffice; never
  // allow a zero-width counter.
  function automatic int cnt_width(input int width);
    cnt_width = ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fas.sv
// Full adder/subtractor cell.
//   a, b  : operand bits
//   cin   : carry in
//   s_op  : 0 = add, 1 = subtract (b is inverted before the add)
//   s     : sum bit
//   cout  : carry out
module fas #(
  parameter int Tpd = 1
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic s_op,
  output logic s,
  output logic cout
);

  logic b_eff;

  // Tpd models cell delay in timing-annotated flows; the logic is zero-delay.
  if (Tpd < 0) begin : g_tpd_neg
  end

  assign b_eff = b ^ s_op;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit two's-complement adder/subtractor using a single fas
// cell. Operand bits are fed LSB first, one pair per clock; the carry lives
// in a flip-flop between cycles.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   a, b    : operands, captured on accepted start
//   sub     : 0 = A+B, 1 = A-B, captured on accepted start
//   busy    : high while bits are being processed
//   done    : one-cycle pulse, result/cout/ovf valid
//   result  : sum/difference, held until the next accepted start
//   cout    : final carry out (subtract: 1 = no borrow)
//   ovf     : signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int Tpd   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             op;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fas_s, fas_cout;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  fas #(.Tpd(Tpd)) u_fas (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s_op (op),
    .s    (fas_s),
    .cout (fas_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op     <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op    <= sub;
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            carry <= sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          result <= {fas_s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fas_cout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // On the MSB, carry still holds the carry into the MSB, so the
            // overflow flag is that XOR the carry coming out of it.
            cout <= fas_cout;
            ovf  <= carry ^ fas_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int vec_cnt = 0;
  int err_cnt = 0;

  serial_addsub #(.WIDTH(W), .Tpd(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    int unsigned full;
    int          sa, sb, exact;
    logic        mo;
    if (ms) full = int'(ma) + ((2**W - 1) - int'(mb)) + 1;
    else    full = int'(ma) + int'(mb);
    sa    = int'($signed(ma));
    sb    = int'($signed(mb));
    exact = ms ? sa - sb : sa + sb;
    mo    = (exact > (2**(W-1) - 1)) || (exact < -(2**(W-1)));
    model = {mo, full[W], full[W-1:0]};
  endfunction

  // Wait for done after an accept edge; returns edges counted past acceptance.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", 32'(n), 32'(W));
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] ta,
                               input logic [W-1:0] tb_, input logic ts);
    logic [W+1:0] exp;
    exp = model(ta, tb_, ts);
    chk({tag, "_result"}, 32'(result), 32'(exp[W-1:0]));
    chk({tag, "_cout"},   32'(cout),   32'(exp[W]));
    chk({tag, "_ovf"},    32'(ovf),    32'(exp[W+1]));
    chk({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic ts);
    int           n;
    logic [W-1:0] held;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'(W));
    check_outputs(tag, ta, tb_, ts);
    held = result;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_held"}, 32'(result), 32'(held));
  endtask

  initial begin
    int n;
    int saw_done;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("add_5_3",   8'h05, 8'h03, 1'b0);
    run_op("add_7f_1",  8'h7F, 8'h01, 1'b0);
    run_op("sub_3_5",   8'h03, 8'h05, 1'b1);
    run_op("sub_80_1",  8'h80, 8'h01, 1'b1);
    run_op("sub_0_80",  8'h00, 8'h80, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0);

    // Start held high through RUN and DONE with different operands
    @(negedge clk);
    a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34;
    wait_done(n);
    chk("hold_lat", 32'(n), 32'(W));
    check_outputs("hold1", 8'hFF, 8'h01, 1'b0);
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("hold_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("hold2_lat", 32'(n), 32'(W));
    check_outputs("hold2", 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;

    // Mid-operation reset
    @(negedge clk);
    a = 8'h55; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_cout", 32'(cout), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("mrst_no_done", 32'(saw_done), 32'd0);
    run_op("post_rst", 8'h05, 8'h03, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
